// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with a registered lookup port, a resolve/update port and a fetch-redirect handshake.
module branch_predictor #(
  parameter int unsigned ENTRIES    = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        predict_valid,
  output logic        predict_taken,
  input  logic        resolve_valid,
  output logic        resolve_ready,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic        resolve_predicted,
  input  logic [31:0] resolve_target,
  input  logic [31:0] resolve_next_pc,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispredict_count
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [1:0]      ctr_q [ENTRIES];
  logic [IdxW-1:0] fetch_idx;
  logic [IdxW-1:0] resolve_idx;
  logic [1:0]      ctr_old;
  logic [1:0]      ctr_new;
  logic            accept;
  logic            mispredict;

  logic            predict_valid_q;
  logic            predict_taken_q;
  logic            redirect_valid_q;
  logic [31:0]     redirect_pc_q;
  logic [15:0]     mispredict_count_q;

  // Only the word-index bits address the table; the rest are deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IdxW+2], fetch_pc[1:0],
                            resolve_pc[31:IdxW+2], resolve_pc[1:0]};

  assign fetch_idx   = fetch_pc[IdxW+1:2];
  assign resolve_idx = resolve_pc[IdxW+1:2];

  assign resolve_ready = !redirect_valid_q || redirect_ready;
  assign accept        = resolve_valid && resolve_ready;
  assign mispredict    = accept && (resolve_taken != resolve_predicted);

  always_comb begin
    ctr_old = ctr_q[resolve_idx];
    ctr_new = ctr_old;
    if (resolve_taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
    end
  end

  // Lookup reads ctr_q before this edge's update, so a same-index collision
  // returns the pre-update counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= INIT_STATE;
      predict_valid_q    <= 1'b0;
      predict_taken_q    <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= 32'h0;
      mispredict_count_q <= 16'h0;
    end else begin
      predict_valid_q <= fetch_valid;
      predict_taken_q <= fetch_valid ? ctr_q[fetch_idx][1] : 1'b0;
      if (accept) ctr_q[resolve_idx] <= ctr_new;
      if (mispredict) begin
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= resolve_taken ? resolve_target : resolve_next_pc;
        if (mispredict_count_q != 16'hFFFF) mispredict_count_q <= mispredict_count_q + 16'd1;
      end else if (redirect_valid_q && redirect_ready) begin
        redirect_valid_q <= 1'b0;
      end
    end
  end

  assign predict_valid    = predict_valid_q;
  assign predict_taken    = predict_taken_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table plus hand-written
// sequences for backpressure, back-to-back redirects, saturation and async reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_predicted;
  logic [31:0] resolve_target;
  logic [31:0] resolve_next_pc;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic pv;
    logic pt;
  } pred_t;
  pred_t pred_q[$];

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic        rp;
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic        rr;
    logic        exp_pt;
    logic        exp_rdv;
    logic [31:0] exp_rdpc;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vecs[11];

  branch_predictor #(.ENTRIES(16), .INIT_STATE(2'b01)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .predict_valid    (predict_valid),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_ready    (resolve_ready),
    .resolve_pc       (resolve_pc),
    .resolve_taken    (resolve_taken),
    .resolve_predicted(resolve_predicted),
    .resolve_target   (resolve_target),
    .resolve_next_pc  (resolve_next_pc),
    .redirect_valid   (redirect_valid),
    .redirect_ready   (redirect_ready),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the prediction expected after the edge.
  task automatic drive(input logic fv, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic rp,
                       input logic [31:0] tgt, input logic [31:0] nxt, input logic rr,
                       input logic exp_pt);
    pred_t p;
    fetch_valid       = fv;
    fetch_pc          = fpc;
    resolve_valid     = rv;
    resolve_pc        = rpc;
    resolve_taken     = rt;
    resolve_predicted = rp;
    resolve_target    = tgt;
    resolve_next_pc   = nxt;
    redirect_ready    = rr;
    p.pv = fv;
    p.pt = fv ? exp_pt : 1'b0;
    pred_q.push_back(p);
  endtask

  task automatic tick();
    pred_t p;
    @(posedge clk);
    #1;
    if (pred_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      p = pred_q.pop_front();
      chk("predict_valid", {31'd0, predict_valid}, {31'd0, p.pv});
      chk("predict_taken", {31'd0, predict_taken}, {31'd0, p.pt});
    end
  endtask

  task automatic chk_redirect(input string tag, input logic rdv, input logic [31:0] rdpc,
                              input logic [15:0] cnt);
    chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rdv});
    chk({tag, "_redirect_pc"}, redirect_pc, rdpc);
    chk({tag, "_mispredict_count"}, {16'd0, mispredict_count}, {16'd0, cnt});
  endtask

  initial begin
    logic prev_rdv;

    //          fv fpc      rv rpc      rt rp tgt      nxt      rr pt rdv rdpc     cnt
    vecs[0]  = '{1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h0,   16'd0};
    vecs[1]  = '{0, 32'h0,   1, 32'h100, 1, 0, 32'h180, 32'h104, 1, 0, 1, 32'h180, 16'd1};
    vecs[2]  = '{0, 32'h0,   1, 32'h100, 1, 0, 32'h180, 32'h104, 1, 0, 1, 32'h180, 16'd2};
    vecs[3]  = '{0, 32'h0,   1, 32'h100, 1, 0, 32'h180, 32'h104, 1, 0, 1, 32'h180, 16'd3};
    vecs[4]  = '{1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1, 0, 32'h180, 16'd3};
    vecs[5]  = '{1, 32'h140, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1, 0, 32'h180, 16'd3};
    vecs[6]  = '{1, 32'h104, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h180, 16'd3};
    vecs[7]  = '{0, 32'h0,   1, 32'h104, 0, 0, 32'h900, 32'h108, 1, 0, 0, 32'h180, 16'd3};
    vecs[8]  = '{1, 32'h104, 1, 32'h104, 1, 1, 32'h900, 32'h108, 1, 0, 0, 32'h180, 16'd3};
    vecs[9]  = '{1, 32'h104, 1, 32'h104, 1, 0, 32'h500, 32'h108, 1, 0, 1, 32'h500, 16'd4};
    vecs[10] = '{1, 32'h104, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1, 0, 32'h500, 16'd4};

    // Reset, with a clock edge and a fetch request while reset is still high.
    reset = 1'b1;
    drive(1, 32'h100, 1, 32'h100, 1, 0, 32'h180, 32'h104, 1, 0);
    void'(pred_q.pop_back());
    @(posedge clk);
    #1;
    chk("reset_predict_valid", {31'd0, predict_valid}, 32'd0);
    chk("reset_predict_taken", {31'd0, predict_taken}, 32'd0);
    chk_redirect("reset", 1'b0, 32'h0, 16'd0);
    reset = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("reset_resolve_ready", {31'd0, resolve_ready}, 32'd1);
    void'(pred_q.pop_back());

    // Vector table.
    prev_rdv = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].rv, vecs[i].rpc, vecs[i].rt, vecs[i].rp,
            vecs[i].tgt, vecs[i].nxt, vecs[i].rr, vecs[i].exp_pt);
      #1;
      chk($sformatf("vec%0d_resolve_ready", i), {31'd0, resolve_ready},
          {31'd0, (!prev_rdv || vecs[i].rr)});
      tick();
      chk_redirect($sformatf("vec%0d", i), vecs[i].exp_rdv, vecs[i].exp_rdpc, vecs[i].exp_cnt);
      prev_rdv = vecs[i].exp_rdv;
    end

    // Redirect held under backpressure; stalled resolves are not accepted.
    drive(0, 32'h0, 1, 32'h200, 1, 0, 32'h400, 32'h204, 0, 0);
    tick();
    chk_redirect("bp_load", 1'b1, 32'h400, 16'd5);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 1, 32'h300, 0, 1, 32'h700, 32'h304, 0, 0);
      #1;
      chk("bp_resolve_ready", {31'd0, resolve_ready}, 32'd0);
      tick();
      chk_redirect("bp_hold", 1'b1, 32'h400, 16'd5);
    end
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    tick();
    chk_redirect("bp_release", 1'b0, 32'h400, 16'd5);

    // Redirect accepted in the same cycle as a new mispredict.
    drive(0, 32'h0, 1, 32'h200, 1, 0, 32'h400, 32'h204, 0, 0);
    tick();
    chk_redirect("b2b_first", 1'b1, 32'h400, 16'd6);
    drive(0, 32'h0, 1, 32'h300, 0, 1, 32'h700, 32'h304, 1, 0);
    #1;
    chk("b2b_resolve_ready", {31'd0, resolve_ready}, 32'd1);
    tick();
    chk_redirect("b2b_second", 1'b1, 32'h304, 16'd7);

    // Count saturation: a mispredict every cycle with redirect_ready held high.
    for (int i = 0; i < 65535; i++) begin
      drive(0, 32'h0, 1, 32'h300, 0, 1, 32'h700, 32'h304, 1, 0);
      tick();
    end
    chk_redirect("sat_full", 1'b1, 32'h304, 16'hFFFF);
    drive(0, 32'h0, 1, 32'h300, 0, 1, 32'h700, 32'h304, 1, 0);
    tick();
    chk_redirect("sat_hold", 1'b1, 32'h304, 16'hFFFF);

    // Asynchronous reset mid-cycle drops a pending redirect without redirect_ready.
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    void'(pred_q.pop_back());
    #2;
    reset = 1'b1;
    #1;
    chk_redirect("async_reset", 1'b0, 32'h0, 16'd0);
    chk("async_reset_predict_valid", {31'd0, predict_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Same-cycle lookup and update of one index returns the pre-update counter.
    drive(1, 32'h100, 1, 32'h100, 1, 1, 32'h180, 32'h104, 1, 0);
    tick();
    chk_redirect("bypass_update", 1'b0, 32'h0, 16'd0);
    drive(1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1);
    tick();

    chk("scoreboard_drained", pred_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
